// File: rtl/datamem_ws.sv
// Data memory with configurable wait states and one-cycle response pulse.
// Ports: clock/reset (sync, high), addr/writeData/size/unsignedLoad/memRead/memWrite in; readData/ready/busy/accessErr out.
module datamem_ws #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] readData,
  output logic        ready,
  output logic        busy,
  output logic        accessErr
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS] =
    '{0: 32'h4, 1: 32'h5, 6: 32'hF, default: 32'h0};

  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_size;
  logic        c_uns, c_rd, c_wr;
  logic [AW-1:0] idx;
  logic [31:0] word, nword, sh;
  logic        oor, mis, err, go, mem_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    nword   = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (memRead || memWrite) begin
          addr_d  = addr;
          wdata_d = writeData;
          size_d  = size;
          uns_d   = unsignedLoad;
          rd_d    = memRead;
          wr_d    = memWrite;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // With zero wait states the access happens on the sampling edge,
    // so the live inputs are used while still in IDLE.
    c_addr  = (state_q == IDLE) ? addr         : addr_q;
    c_wdata = (state_q == IDLE) ? writeData    : wdata_q;
    c_size  = (state_q == IDLE) ? size         : size_q;
    c_uns   = (state_q == IDLE) ? unsignedLoad : uns_q;
    c_rd    = (state_q == IDLE) ? memRead      : rd_q;
    c_wr    = (state_q == IDLE) ? memWrite     : wr_q;

    idx  = c_addr[AW+1:2];
    word = mem_q[idx];
    sh   = word >> {c_addr[1:0], 3'b000};
    oor  = |(c_addr >> (AW + 2));
    mis  = ((c_size == 2'b01) && c_addr[0]) ||
           ((c_size == 2'b10) && (c_addr[1:0] != 2'b00));
    err  = oor || mis || (c_size == 2'b11) || (c_rd && c_wr);

    // Array and readData are updated on the edge that enters RESP,
    // so readData is valid while ready is high.
    go = (state_d == RESP) && (state_q != RESP);

    if (go) begin
      if (err) begin
        err_d   = 1'b1;
        rdata_d = 32'h0;
      end else if (c_wr) begin
        err_d  = 1'b0;
        mem_we = 1'b1;
        nword  = word;
        case (c_size)
          2'b00:   nword[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
          2'b01:   nword[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
          default: nword = c_wdata;
        endcase
      end else begin
        err_d = 1'b0;
        case (c_size)
          2'b00:   rdata_d = c_uns ? {24'h0, sh[7:0]}
                                   : {{24{sh[7]}}, sh[7:0]};
          2'b01:   rdata_d = c_uns ? {16'h0, sh[15:0]}
                                   : {{16{sh[15]}}, sh[15:0]};
          default: rdata_d = word;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem_q[idx] <= nword;
  end

  assign readData  = rdata_q;
  assign ready     = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign accessErr = err_q;
endmodule

// File: tb/tb_datamem_ws.sv
// Testbench for datamem_ws: table of directed accesses plus reset/busy sequences.
// Two instances: zero wait states and three wait states.
module tb_datamem_ws;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, writeData;
  logic        rd0, wr0, rd3, wr3;
  logic [1:0]  size;
  logic        unsignedLoad;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, busy0, busy3, err0, err3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  datamem_ws #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
    .clock(clock), .reset(reset), .addr(addr), .writeData(writeData),
    .memRead(rd0), .memWrite(wr0), .size(size),
    .unsignedLoad(unsignedLoad), .readData(rdata0), .ready(ready0),
    .busy(busy0), .accessErr(err0)
  );

  datamem_ws #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u3 (
    .clock(clock), .reset(reset), .addr(addr), .writeData(writeData),
    .memRead(rd3), .memWrite(wr3), .size(size),
    .unsignedLoad(unsignedLoad), .readData(rdata3), .ready(ready3),
    .busy(busy3), .accessErr(err3)
  );

  typedef struct {
    bit          w3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        r;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic req(input bit w3, input logic [31:0] a, wd,
                     input logic r, w, input logic [1:0] sz,
                     input logic u, output logic [31:0] rd,
                     output logic er, output int lat);
    @(negedge clock);
    addr = a; writeData = wd; size = sz; unsignedLoad = u;
    if (w3) begin rd3 = r; wr3 = w; end
    else begin rd0 = r; wr0 = w; end
    @(posedge clock);
    #1;
    rd0 = 0; wr0 = 0; rd3 = 0; wr3 = 0;
    lat = 0;
    rd = 32'hx; er = 1'bx;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (w3 ? ready3 : ready0) begin
        rd = w3 ? rdata3 : rdata0;
        er = w3 ? err3 : err0;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, cnt;

    reset = 1; addr = 0; writeData = 0; size = 0; unsignedLoad = 0;
    rd0 = 0; wr0 = 0; rd3 = 0; wr3 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_ready0", {31'h0, ready0}, 32'h0);
    chk("rst_busy3", {31'h0, busy3}, 32'h0);
    chk("rst_err3", {31'h0, err3}, 32'h0);
    reset = 0;

    v.push_back('{0, 32'h18, 32'h0, 1, 0, 2'b10, 0, 32'h0000000F, 0});
    v.push_back('{1, 32'h05, 32'h80, 0, 1, 2'b00, 0, 32'h00000000, 0});
    v.push_back('{1, 32'h05, 32'h0, 1, 0, 2'b00, 0, 32'hFFFFFF80, 0});
    v.push_back('{1, 32'h05, 32'h0, 1, 0, 2'b00, 1, 32'h00000080, 0});
    v.push_back('{1, 32'h04, 32'h0, 1, 0, 2'b10, 0, 32'h00008005, 0});
    v.push_back('{1, 32'h06, 32'hBEEF, 0, 1, 2'b01, 0, 32'h00008005, 0});
    v.push_back('{1, 32'h04, 32'h0, 1, 0, 2'b10, 1, 32'hBEEF8005, 0});
    v.push_back('{1, 32'h06, 32'h0, 1, 0, 2'b01, 0, 32'hFFFFBEEF, 0});
    v.push_back('{1, 32'h06, 32'h0, 1, 0, 2'b01, 1, 32'h0000BEEF, 0});
    v.push_back('{1, 32'h04, 32'h0, 1, 0, 2'b01, 0, 32'hFFFF8005, 0});
    v.push_back('{1, 32'h03, 32'hBEEF, 0, 1, 2'b01, 0, 32'h0, 1});
    v.push_back('{1, 32'h00, 32'h0, 1, 0, 2'b10, 0, 32'h00000004, 0});
    v.push_back('{1, 32'h400, 32'h0, 1, 0, 2'b10, 0, 32'h0, 1});
    v.push_back('{1, 32'h08, 32'hDEADBEEF, 1, 1, 2'b10, 0, 32'h0, 1});
    v.push_back('{1, 32'h08, 32'h0, 1, 0, 2'b10, 0, 32'h0, 0});
    v.push_back('{1, 32'h01, 32'h0, 1, 0, 2'b10, 0, 32'h0, 1});
    v.push_back('{1, 32'h00, 32'h0, 1, 0, 2'b11, 0, 32'h0, 1});
    v.push_back('{1, 32'h00, 32'h11, 0, 1, 2'b00, 0, 32'h0, 0});
    v.push_back('{1, 32'h00, 32'h0, 1, 0, 2'b10, 0, 32'h00000011, 0});
    v.push_back('{0, 32'h10, 32'h12345678, 0, 1, 2'b10, 0, 32'h0000000F, 0});
    v.push_back('{0, 32'h13, 32'h0, 1, 0, 2'b00, 1, 32'h00000012, 0});
    v.push_back('{0, 32'h12, 32'h0, 1, 0, 2'b00, 0, 32'h00000034, 0});
    v.push_back('{0, 32'h10, 32'h0, 1, 0, 2'b01, 1, 32'h00005678, 0});
    v.push_back('{0, 32'h3FF, 32'h0, 1, 0, 2'b00, 0, 32'h000000FF, 1});

    // Last entry is in range; fix its expectation: byte at 0x3FF is 0.
    v[v.size()-1].erd = 32'h0;
    v[v.size()-1].eerr = 0;

    foreach (v[i]) begin
      req(v[i].w3, v[i].a, v[i].wd, v[i].r, v[i].w, v[i].sz, v[i].u,
          rd, er, lat);
      chk($sformatf("v%0d_lat", i), lat, v[i].w3 ? 4 : 1);
      chk($sformatf("v%0d_rdata", i), rd, v[i].erd);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, v[i].eerr});
    end

    // Reset during WAIT aborts a word store; request during reset ignored.
    @(negedge clock);
    addr = 32'h20; writeData = 32'h12345678; size = 2'b10; wr3 = 1;
    @(posedge clock);
    #1 wr3 = 0;
    @(negedge clock);
    chk("mid_busy", {31'h0, busy3}, 32'h1);
    reset = 1; rd3 = 1; addr = 32'h18;
    @(negedge clock);
    chk("rst_busy_after", {31'h0, busy3}, 32'h0);
    chk("rst_rdata_after", rdata3, 32'h0);
    reset = 0; rd3 = 0;
    @(negedge clock);
    chk("rst_req_ignored", {31'h0, busy3}, 32'h0);
    req(1, 32'h20, 0, 1, 0, 2'b10, 0, rd, er, lat);
    chk("abort_no_store", rd, 32'h0);
    req(1, 32'h00, 0, 1, 0, 2'b10, 0, rd, er, lat);
    chk("rst_keeps_mem", rd, 32'h00000011);

    // Requests held while busy are ignored; captured addr is used.
    @(negedge clock);
    addr = 32'h04; size = 2'b10; rd3 = 1;
    @(posedge clock);
    #1 addr = 32'h18;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k == 2) rd3 = 0;
      if (ready3) begin
        cnt++;
        chk("busy_rdata", rdata3, 32'hBEEF8005);
      end
    end
    chk("busy_one_pulse", cnt, 1);

    // Back-to-back: held request accepted every two cycles at WS=0.
    @(negedge clock);
    addr = 32'h18; size = 2'b10; rd0 = 1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (ready0) cnt++;
    end
    rd0 = 0;
    chk("b2b_pulses", cnt, 4);
    chk("b2b_rdata", rdata0, 32'h0000000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
